// File: rtl/uart_pkg.sv
// Shared constants and state encodings for the UART console.
package uart_pkg;

  localparam int unsigned DIV16_DEFAULT = 326;
  localparam int unsigned BITS          = 8;
  localparam int unsigned OVERSAMPLE    = 16;
  localparam int unsigned TICK_W        = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_IDX_W     = $clog2(BITS);

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_t;

endpackage

// File: rtl/uart_baud_gen.sv
// Free-running 16x oversample tick generator shared by TX and RX.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int unsigned DIV16 = DIV16_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int unsigned CNT_W = $clog2(DIV16);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV16 - 1);

  logic [CNT_W-1:0] count;

  // Count 0..DIV16-1 and wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/uart_console.sv
// 8N1 UART transmitter and receiver sharing one oversample tick.
module uart_console
  import uart_pkg::*;
#(
  parameter int unsigned DIV16 = DIV16_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_load,
  output logic       tx_ready,
  output logic       rs232_tx,
  input  logic       rs232_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       rx_overrun,
  output logic       rx_frame_err
);

  localparam logic [TICK_W-1:0]    TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [TICK_W-1:0]    TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [BIT_IDX_W-1:0] BIT_LAST  = BIT_IDX_W'(BITS - 1);

  logic tick;

  uart_baud_gen #(.DIV16(DIV16)) u_baud_gen (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  // Transmitter state and next-state signals
  tx_state_t            tx_state, tx_state_n;
  logic [TICK_W-1:0]    tx_tick_cnt, tx_tick_cnt_n;
  logic [BIT_IDX_W-1:0] tx_bit_idx, tx_bit_idx_n;
  logic [7:0]           tx_shift, tx_shift_n;
  logic                 tx_line_n;
  logic                 tx_ready_n;

  // Receiver state and next-state signals
  rx_state_t            rx_state, rx_state_n;
  logic [TICK_W-1:0]    rx_tick_cnt, rx_tick_cnt_n;
  logic [BIT_IDX_W-1:0] rx_bit_idx, rx_bit_idx_n;
  logic [7:0]           rx_shift, rx_shift_n;
  logic [7:0]           rx_data_n;
  logic                 rx_valid_n, rx_overrun_n, rx_frame_err_n;
  logic                 rx_meta, rx_sync;
  logic                 deliver, frame_bad;

  // Transmitter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state    <= TX_IDLE;
      tx_tick_cnt <= '0;
      tx_bit_idx  <= '0;
      tx_shift    <= '0;
      rs232_tx    <= 1'b1;
      tx_ready    <= 1'b1;
    end else begin
      tx_state    <= tx_state_n;
      tx_tick_cnt <= tx_tick_cnt_n;
      tx_bit_idx  <= tx_bit_idx_n;
      tx_shift    <= tx_shift_n;
      rs232_tx    <= tx_line_n;
      tx_ready    <= tx_ready_n;
    end
  end

  // Transmitter next state: each bit held for 16 ticks, LSB first.
  always_comb begin
    tx_state_n    = tx_state;
    tx_tick_cnt_n = tx_tick_cnt;
    tx_bit_idx_n  = tx_bit_idx;
    tx_shift_n    = tx_shift;
    tx_line_n     = rs232_tx;
    unique case (tx_state)
      TX_IDLE: begin
        tx_line_n = 1'b1;
        if (tx_load) begin
          tx_state_n    = TX_START;
          tx_shift_n    = tx_data;
          tx_tick_cnt_n = '0;
          tx_line_n     = 1'b0;
        end
      end
      TX_START: begin
        if (tick) begin
          tx_tick_cnt_n = tx_tick_cnt + 1'b1;
          if (tx_tick_cnt == TICK_LAST) begin
            tx_state_n   = TX_DATA;
            tx_bit_idx_n = '0;
            tx_line_n    = tx_shift[0];
          end
        end
      end
      TX_DATA: begin
        if (tick) begin
          tx_tick_cnt_n = tx_tick_cnt + 1'b1;
          if (tx_tick_cnt == TICK_LAST) begin
            if (tx_bit_idx == BIT_LAST) begin
              tx_state_n = TX_STOP;
              tx_line_n  = 1'b1;
            end else begin
              tx_bit_idx_n = tx_bit_idx + 1'b1;
              tx_shift_n   = {1'b0, tx_shift[7:1]};
              tx_line_n    = tx_shift[1];
            end
          end
        end
      end
      TX_STOP: begin
        if (tick) begin
          tx_tick_cnt_n = tx_tick_cnt + 1'b1;
          if (tx_tick_cnt == TICK_LAST) begin
            tx_state_n = TX_IDLE;
            tx_line_n  = 1'b1;
          end
        end
      end
      default: begin
        tx_state_n = TX_IDLE;
        tx_line_n  = 1'b1;
      end
    endcase
    tx_ready_n = (tx_state_n == TX_IDLE);
  end

  // Receiver registers, including the input synchronizer.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta      <= 1'b1;
      rx_sync      <= 1'b1;
      rx_state     <= RX_IDLE;
      rx_tick_cnt  <= '0;
      rx_bit_idx   <= '0;
      rx_shift     <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_overrun   <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_meta      <= rs232_rx;
      rx_sync      <= rx_meta;
      rx_state     <= rx_state_n;
      rx_tick_cnt  <= rx_tick_cnt_n;
      rx_bit_idx   <= rx_bit_idx_n;
      rx_shift     <= rx_shift_n;
      rx_data      <= rx_data_n;
      rx_valid     <= rx_valid_n;
      rx_overrun   <= rx_overrun_n;
      rx_frame_err <= rx_frame_err_n;
    end
  end

  // Receiver next state: mid-bit sampling, then delivery and status flags.
  always_comb begin
    rx_state_n    = rx_state;
    rx_tick_cnt_n = rx_tick_cnt;
    rx_bit_idx_n  = rx_bit_idx;
    rx_shift_n    = rx_shift;
    deliver       = 1'b0;
    frame_bad     = 1'b0;
    unique case (rx_state)
      RX_IDLE: begin
        if (!rx_sync) begin
          rx_state_n    = RX_START;
          rx_tick_cnt_n = '0;
        end
      end
      RX_START: begin
        if (tick) begin
          rx_tick_cnt_n = rx_tick_cnt + 1'b1;
          if (rx_tick_cnt == TICK_MID) begin
            rx_tick_cnt_n = '0;
            rx_bit_idx_n  = '0;
            rx_state_n    = rx_sync ? RX_IDLE : RX_DATA;
          end
        end
      end
      RX_DATA: begin
        if (tick) begin
          rx_tick_cnt_n = rx_tick_cnt + 1'b1;
          if (rx_tick_cnt == TICK_LAST) begin
            rx_shift_n = {rx_sync, rx_shift[7:1]};
            if (rx_bit_idx == BIT_LAST) begin
              rx_state_n = RX_STOP;
            end else begin
              rx_bit_idx_n = rx_bit_idx + 1'b1;
            end
          end
        end
      end
      RX_STOP: begin
        if (tick) begin
          rx_tick_cnt_n = rx_tick_cnt + 1'b1;
          if (rx_tick_cnt == TICK_LAST) begin
            if (rx_sync) begin
              deliver    = 1'b1;
              rx_state_n = RX_IDLE;
            end else begin
              frame_bad  = 1'b1;
              rx_state_n = RX_WAIT_HIGH;
            end
          end
        end
      end
      RX_WAIT_HIGH: begin
        if (rx_sync) begin
          rx_state_n = RX_IDLE;
        end
      end
      default: rx_state_n = RX_IDLE;
    endcase

    rx_data_n      = rx_data;
    rx_valid_n     = rx_valid;
    rx_overrun_n   = rx_overrun;
    rx_frame_err_n = rx_frame_err;
    if (rx_ack) begin
      rx_valid_n     = 1'b0;
      rx_overrun_n   = 1'b0;
      rx_frame_err_n = 1'b0;
    end
    // A byte arriving while the previous one is still unread is dropped.
    if (deliver) begin
      rx_valid_n = 1'b1;
      if (!rx_valid || rx_ack) begin
        rx_data_n = rx_shift;
      end else begin
        rx_overrun_n = 1'b1;
      end
    end
    if (frame_bad) begin
      rx_frame_err_n = 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_console.sv
// Randomized self-checking bench for uart_console with a time-based line model.
module tb_uart_console;

  localparam int DIV   = 4;
  localparam int BITC  = 16 * DIV;          // cycles per bit
  localparam int SEND  = 15 * DIV;          // start bit ends at 16th tick
  localparam int TXEND = SEND + 9 * BITC;   // tx idle again
  localparam int RXDLY = 7 * DIV + 9 * BITC; // first tick -> stop sample

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_load;
  logic       tx_ready;
  logic       rs232_tx;
  logic       rs232_rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ack;
  logic       rx_overrun;
  logic       rx_frame_err;

  always #5 clk = ~clk;

  uart_console #(.DIV16(DIV)) dut (
    .clk          (clk),
    .reset        (reset),
    .tx_data      (tx_data),
    .tx_load      (tx_load),
    .tx_ready     (tx_ready),
    .rs232_tx     (rs232_tx),
    .rs232_rx     (rs232_rx),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ack       (rx_ack),
    .rx_overrun   (rx_overrun),
    .rx_frame_err (rx_frame_err)
  );

  // Edges since the last reset edge; ticks land on multiples of DIV.
  int ecount;
  bit chk_en = 1'b0;
  int passed = 0;
  int total  = 0;

  // TX model: frame anchored to accept edge and first tick after it.
  bit         m_tx_busy;
  int         m_tx_t;
  logic [7:0] m_tx_byte;

  // RX model: scheduled delivery events plus status flags.
  typedef struct {
    int         at;
    logic [7:0] b;
    logic       ok;
  } rx_ev_t;
  rx_ev_t     rxq[$];
  logic       m_rv, m_ro, m_rf;
  logic [7:0] m_rd;
  int         rx_due;
  bit         rx_abort = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, ecount);
  endtask

  function automatic logic exp_tx(input int e);
    int d;
    if (!m_tx_busy) return 1'b1;
    d = e - (m_tx_t + SEND);
    if (d < 0) return 1'b0;
    if (d / BITC < 8) return m_tx_byte[d / BITC];
    return 1'b1;
  endfunction

  function automatic logic exp_ready(input int e);
    return !m_tx_busy || (e >= m_tx_t + TXEND);
  endfunction

  // Model update on every rising edge.
  always @(posedge clk) begin
    logic nv, no, nf;
    logic [7:0] nd;
    rx_ev_t ev;
    if (reset) begin
      ecount    = 0;
      m_tx_busy = 1'b0;
      rxq.delete();
      m_rv = 1'b0; m_ro = 1'b0; m_rf = 1'b0; m_rd = 8'h00;
      chk_en = 1'b1;
    end else begin
      ecount++;
      if (tx_load && exp_ready(ecount - 1)) begin
        m_tx_busy = 1'b1;
        m_tx_byte = tx_data;
        m_tx_t    = (ecount / DIV + 1) * DIV;
      end
      nv = m_rv; no = m_ro; nf = m_rf; nd = m_rd;
      if (rx_ack) begin
        nv = 1'b0; no = 1'b0; nf = 1'b0;
      end
      if (rxq.size() > 0 && rxq[0].at == ecount) begin
        ev = rxq.pop_front();
        if (ev.ok) begin
          if (!m_rv || rx_ack) nd = ev.b;
          else no = 1'b1;
          nv = 1'b1;
        end else begin
          nf = 1'b1;
        end
      end
      m_rv = nv; m_ro = no; m_rf = nf; m_rd = nd;
    end
  end

  // Compare all outputs every cycle on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("rs232_tx", 32'(rs232_tx), 32'(exp_tx(ecount)));
      chk("tx_ready", 32'(tx_ready), 32'(exp_ready(ecount)));
      chk("rx_valid", 32'(rx_valid), 32'(m_rv));
      chk("rx_data", 32'(rx_data), 32'(m_rd));
      chk("rx_overrun", 32'(rx_overrun), 32'(m_ro));
      chk("rx_frame_err", 32'(rx_frame_err), 32'(m_rf));
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_until(input int target);
    int n = 0;
    while (ecount < target && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    if (ecount < target) begin
      total++;
      $display("FAIL wait_until: reached edge %0d, required %0d", ecount, target);
    end
  endtask

  task automatic tx_send(input logic [7:0] b);
    @(posedge clk); #1;
    tx_data = b;
    tx_load = 1'b1;
    @(posedge clk); #1;
    tx_load = 1'b0;
  endtask

  task automatic ack_pulse();
    @(posedge clk); #1;
    rx_ack = 1'b1;
    @(posedge clk); #1;
    rx_ack = 1'b0;
  endtask

  task automatic rx_frame(input logic [7:0] b, input logic stop_ok);
    logic [9:0] fr;
    rx_ev_t ev;
    fr = {stop_ok, b, 1'b0};
    @(posedge clk); #1;
    ev.at = ((ecount + 3) / DIV + 1) * DIV + RXDLY;
    ev.b  = b;
    ev.ok = stop_ok;
    rxq.push_back(ev);
    rx_due = ev.at;
    for (int i = 0; i < 10; i++) begin
      rs232_rx = fr[i];
      for (int c = 0; c < BITC; c++) begin
        if (rx_abort) begin
          rs232_rx = 1'b1;
          return;
        end
        @(posedge clk); #1;
      end
    end
    rs232_rx = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int exp_bits[8];
    exp_bits = '{1, 0, 0, 0, 0, 0, 1, 0};
    reset = 1'b1; tx_load = 1'b0; tx_data = 8'h00; rs232_rx = 1'b1; rx_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset values
    @(negedge clk);
    chk("rst_tx", 32'(rs232_tx), 32'd1);
    chk("rst_ready", 32'(tx_ready), 32'd1);
    chk("rst_valid", 32'(rx_valid), 32'd0);
    chk("rst_data", 32'(rx_data), 32'd0);
    chk("rst_overrun", 32'(rx_overrun), 32'd0);
    chk("rst_frame_err", 32'(rx_frame_err), 32'd0);

    // Transmit 0x41 with an ignored load mid-frame
    tx_send(8'h41);
    @(negedge clk);
    chk("lit_ready_after_load", 32'(tx_ready), 32'd0);
    chk("lit_tx_after_load", 32'(rs232_tx), 32'd0);
    for (int i = 0; i < 8; i++) begin
      if (i == 3) tx_send(8'hFF);
      wait_until(m_tx_t + SEND + BITC / 2 + BITC * i);
      @(negedge clk);
      chk("lit_tx_bit", 32'(rs232_tx), 32'(exp_bits[i]));
    end
    wait_until(m_tx_t + SEND + 8 * BITC + BITC / 2);
    @(negedge clk);
    chk("lit_tx_stop", 32'(rs232_tx), 32'd1);
    wait_until(m_tx_t + TXEND - 1);
    @(negedge clk);
    chk("lit_ready_in_stop", 32'(tx_ready), 32'd0);
    wait_until(m_tx_t + TXEND);
    @(negedge clk);
    chk("lit_ready_done", 32'(tx_ready), 32'd1);

    // Receive 0xA5
    rx_frame(8'hA5, 1'b1);
    @(negedge clk);
    chk("lit_rx_valid", 32'(rx_valid), 32'd1);
    chk("lit_rx_data", 32'(rx_data), 32'h0A5);
    ack_pulse();
    @(negedge clk);
    chk("lit_rx_acked", 32'(rx_valid), 32'd0);

    // Overrun
    rx_frame(8'h11, 1'b1);
    rx_frame(8'h22, 1'b1);
    @(negedge clk);
    chk("lit_ovr_data", 32'(rx_data), 32'h011);
    chk("lit_ovr_flag", 32'(rx_overrun), 32'd1);
    ack_pulse();
    @(negedge clk);
    chk("lit_ovr_clr_valid", 32'(rx_valid), 32'd0);
    chk("lit_ovr_clr_flag", 32'(rx_overrun), 32'd0);

    // Frame error then a good byte
    rx_frame(8'h33, 1'b0);
    idle(20);
    @(negedge clk);
    chk("lit_fe_valid", 32'(rx_valid), 32'd0);
    chk("lit_fe_flag", 32'(rx_frame_err), 32'd1);
    ack_pulse();
    rx_frame(8'h44, 1'b1);
    @(negedge clk);
    chk("lit_fe_next_data", 32'(rx_data), 32'h044);
    chk("lit_fe_next_valid", 32'(rx_valid), 32'd1);
    ack_pulse();

    // Glitch on rx line
    @(posedge clk); #1;
    rs232_rx = 1'b0;
    idle(20);
    rs232_rx = 1'b1;
    idle(700);
    @(negedge clk);
    chk("lit_glitch_valid", 32'(rx_valid), 32'd0);

    // Delivery coinciding with an ack of the pending byte
    rx_frame(8'h77, 1'b1);
    fork
      rx_frame(8'h55, 1'b1);
      begin
        idle(3);
        wait_until(rx_due - 1);
        rx_ack = 1'b1;
        @(posedge clk); #1;
        rx_ack = 1'b0;
      end
    join
    @(negedge clk);
    chk("lit_sim_data", 32'(rx_data), 32'h055);
    chk("lit_sim_valid", 32'(rx_valid), 32'd1);
    chk("lit_sim_overrun", 32'(rx_overrun), 32'd0);
    ack_pulse();

    // Random concurrent traffic
    fork
      for (int i = 0; i < 6; i++) begin
        tx_send(8'($urandom));
        if ($urandom_range(0, 1) == 1) begin
          wait_until(m_tx_t + int'($urandom_range(0, 500)));
          tx_send(8'($urandom));
        end
        wait_until(m_tx_t + TXEND + int'($urandom_range(0, 20)));
      end
      for (int i = 0; i < 6; i++) begin
        rx_frame(8'($urandom), $urandom_range(0, 3) != 0);
        idle(int'($urandom_range(1, 40)));
      end
      for (int i = 0; i < 4000; i++) begin
        @(posedge clk); #1;
        rx_ack = ($urandom_range(0, 99) == 0);
      end
    join
    rx_ack = 1'b0;
    ack_pulse();
    idle(700);

    // Reset during the 4th TX data bit with an RX frame in flight
    fork
      rx_frame(8'hC3, 1'b1);
      begin
        tx_send(8'h5A);
        wait_until(m_tx_t + SEND + 3 * BITC + 20);
        reset = 1'b1;
        rx_abort = 1'b1;
        rs232_rx = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("lit_rst_tx", 32'(rs232_tx), 32'd1);
        chk("lit_rst_ready", 32'(tx_ready), 32'd1);
      end
    join
    rx_abort = 1'b0;
    idle(1000);
    @(negedge clk);
    chk("lit_rst_no_rx", 32'(rx_valid), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
